// File: rtl/program_counter_unit_if.sv
// Decoder/bus-side signal bundle for program_counter_unit.
// The master modport is the decoder and memory side; the slave modport is the PC unit.
interface program_counter_unit_if;
  logic        pc_enable;
  logic        address_select;
  logic [15:0] memory_address;
  logic [7:0]  data_in;
  logic        pcl_latch;
  logic        pc_load;
  logic [15:0] address_bus;
  logic [15:0] pc;
  logic        pc_valid;

  modport master (
    output pc_enable, address_select, memory_address, data_in, pcl_latch, pc_load,
    input  address_bus, pc, pc_valid
  );

  modport slave (
    input  pc_enable, address_select, memory_address, data_in, pcl_latch, pc_load,
    output address_bus, pc, pc_valid
  );
endinterface

// File: rtl/program_counter_unit.sv
// 16-bit program counter with address-bus mux, two-byte jump load and reset-vector fetch.
// Define RESET_VECTOR_FETCH_EN to fetch the start PC from RESET_VECTOR_ADDR; otherwise reset loads RESET_PC.
module program_counter_unit #(
  parameter logic [15:0] RESET_VECTOR_ADDR = 16'hFFFC,
  parameter logic [15:0] RESET_PC          = 16'h0000
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rdy,
  program_counter_unit_if.slave bus
);

  logic [15:0] pc_q;
  logic [15:0] run_pc_next;
  logic [15:0] run_addr;
  logic [7:0]  pcl_q;
  logic [7:0]  pcl_next;
  logic        running;

  // Normal-operation update: a load wins over an increment raised in the same cycle.
  // NOTE: always_comb assigns a default first so every path drives the output and no latch is inferred.
  always_comb begin
    run_pc_next = pc_q;
    if (bus.pc_load) begin
      run_pc_next = {bus.data_in, pcl_q};
    end else if (bus.pc_enable) begin
      run_pc_next = pc_q + 16'd1;
    end
  end

  assign run_addr = bus.address_select ? bus.memory_address : pc_q;
  assign pcl_next = (running && bus.pcl_latch) ? bus.data_in : pcl_q;

`ifdef RESET_VECTOR_FETCH_EN
  typedef enum logic [1:0] {S_VEC_LO, S_VEC_HI, S_RUN} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc_next;
  logic [15:0] addr;
  logic        unused_reset_pc;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= S_VEC_LO;
      pc_q  <= 16'h0000;
      pcl_q <= 8'h00;
    end else if (rdy) begin
      state <= state_next;
      pc_q  <= pc_next;
      pcl_q <= pcl_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    addr       = pc_q;
    case (state)
      S_VEC_LO: begin
        addr       = RESET_VECTOR_ADDR;
        pc_next    = {pc_q[15:8], bus.data_in};
        state_next = S_VEC_HI;
      end
      S_VEC_HI: begin
        addr       = RESET_VECTOR_ADDR + 16'd1;
        pc_next    = {bus.data_in, pc_q[7:0]};
        state_next = S_RUN;
      end
      S_RUN: begin
        addr    = run_addr;
        pc_next = run_pc_next;
      end
      default: state_next = S_VEC_LO;
    endcase
  end

  assign running         = (state == S_RUN);
  assign bus.address_bus = addr;
  assign unused_reset_pc = ^RESET_PC;
`else
  logic unused_vector_addr;

  // Without the vector fetch the unit is live from the reset edge onward.
  always_ff @(posedge clk) begin
    if (res) begin
      running <= 1'b1;
      pc_q    <= RESET_PC;
      pcl_q   <= 8'h00;
    end else if (rdy) begin
      pc_q  <= run_pc_next;
      pcl_q <= pcl_next;
    end
  end

  assign bus.address_bus    = run_addr;
  assign unused_vector_addr = ^RESET_VECTOR_ADDR;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_valid = running;

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit: a byte-level reference model checked every cycle,
// plus directed literal expectations; follows RESET_VECTOR_FETCH_EN the same way the design does.
module tb_program_counter_unit;
  localparam logic [15:0] VEC_ADDR = 16'hFFFC;
  localparam logic [15:0] RST_PC   = 16'h8000;

  logic clk = 1'b0;
  logic res;
  logic rdy;
  int   n_tests = 0;
  int   n_fail  = 0;

  program_counter_unit_if bus ();

  program_counter_unit #(
    .RESET_VECTOR_ADDR(VEC_ADDR),
    .RESET_PC         (RST_PC)
  ) dut (
    .clk(clk),
    .res(res),
    .rdy(rdy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vector bytes still to fetch, the PC value and the held low byte.
  bit          m_ok = 1'b0;
  int          m_fetch_left;
  logic [15:0] m_pc;
  logic [7:0]  m_hold;

  always @(posedge clk) begin
    if (res) begin
      m_ok   <= 1'b1;
      m_hold <= 8'h00;
`ifdef RESET_VECTOR_FETCH_EN
      m_fetch_left <= 2;
      m_pc         <= 16'h0000;
`else
      m_fetch_left <= 0;
      m_pc         <= RST_PC;
`endif
    end else if (m_ok && rdy) begin
      if (m_fetch_left == 2) begin
        m_pc[7:0]    <= bus.data_in;
        m_fetch_left <= 1;
      end else if (m_fetch_left == 1) begin
        m_pc[15:8]   <= bus.data_in;
        m_fetch_left <= 0;
      end else begin
        if (bus.pc_load)        m_pc <= {bus.data_in, m_hold};
        else if (bus.pc_enable) m_pc <= 16'(m_pc + 16'd1);
        if (bus.pcl_latch)      m_hold <= bus.data_in;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_addr;
    if (m_ok) begin
      if (m_fetch_left == 2)      exp_addr = VEC_ADDR;
      else if (m_fetch_left == 1) exp_addr = 16'(VEC_ADDR + 16'd1);
      else                        exp_addr = bus.address_select ? bus.memory_address : m_pc;
      check("model_pc",       bus.pc, m_pc);
      check("model_addr",     bus.address_bus, exp_addr);
      check("model_pc_valid", {15'd0, bus.pc_valid}, {15'd0, m_fetch_left == 0});
    end
  end

  // Advance one clock edge and settle just past the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic latch, input logic load, input logic [7:0] data);
    bus.pc_enable = en;
    bus.pcl_latch = latch;
    bus.pc_load   = load;
    bus.data_in   = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1;
    rdy = 1'b1;
    bus.address_select = 1'b0;
    bus.memory_address = 16'h0000;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cyc();

`ifdef RESET_VECTOR_FETCH_EN
    check("rst_valid", {15'd0, bus.pc_valid}, 16'h0000);
    check("rst_addr",  bus.address_bus, 16'hFFFC);
    check("rst_pc",    bus.pc, 16'h0000);
    res = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h34);
    cyc();
    check("vechi_addr", bus.address_bus, 16'hFFFD);
    check("vechi_pc",   bus.pc, 16'h0034);
    rdy = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h99);
    cyc();
    check("stall_addr",  bus.address_bus, 16'hFFFD);
    check("stall_pc",    bus.pc, 16'h0034);
    check("stall_valid", {15'd0, bus.pc_valid}, 16'h0000);
    rdy = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h12);
    cyc();
`else
    check("rst_valid", {15'd0, bus.pc_valid}, 16'h0001);
    check("rst_pc",    bus.pc, 16'h8000);
    res = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cyc();
    check("first_inc", bus.pc, 16'h8001);
    drive(1'b0, 1'b1, 1'b0, 8'h34);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 8'h12);
    cyc();
`endif
    check("run_pc",    bus.pc, 16'h1234);
    check("run_valid", {15'd0, bus.pc_valid}, 16'h0001);
    check("run_addr",  bus.address_bus, 16'h1234);

    drive(1'b0, 1'b0, 1'b0, 8'h00);
    bus.address_select = 1'b1;
    bus.memory_address = 16'h0042;
    #1;
    check("mux_operand", bus.address_bus, 16'h0042);
    bus.address_select = 1'b0;
    #1;
    check("mux_pc", bus.address_bus, 16'h1234);

    drive(1'b0, 1'b1, 1'b0, 8'hCD);
    cyc();
    drive(1'b1, 1'b0, 1'b1, 8'hAB);
    cyc();
    check("jump_load", bus.pc, 16'hABCD);

    // Latch and load together: the load must see the previous low byte.
    drive(1'b0, 1'b1, 1'b1, 8'hFE);
    cyc();
    check("load_old_hold", bus.pc, 16'hFECD);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    cyc();
    check("load_new_hold", bus.pc, 16'hFFFE);

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cyc();
    check("inc_ffff", bus.pc, 16'hFFFF);
    cyc();
    check("inc_wrap", bus.pc, 16'h0000);

    rdy = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    cyc();
    check("rdy_hold_pc", bus.pc, 16'h0000);
    rdy = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'h55);
    cyc();
    check("rdy_hold_pcl", bus.pc, 16'h55FE);

    res = 1'b1;
    rdy = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cyc();
`ifdef RESET_VECTOR_FETCH_EN
    check("midrun_rst_addr",  bus.address_bus, 16'hFFFC);
    check("midrun_rst_valid", {15'd0, bus.pc_valid}, 16'h0000);
    check("midrun_rst_pc",    bus.pc, 16'h0000);
    res = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h11);
    cyc();
    check("veclo_stall_addr", bus.address_bus, 16'hFFFC);
    rdy = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h22);
    cyc();
    check("veclo_ignore", bus.pc, 16'h0022);
    drive(1'b1, 1'b1, 1'b1, 8'h33);
    cyc();
    check("vechi_ignore", bus.pc, 16'h3322);
    drive(1'b0, 1'b0, 1'b1, 8'h44);
    cyc();
    check("vec_no_latch", bus.pc, 16'h4400);
`else
    check("midrun_rst_pc",    bus.pc, 16'h8000);
    check("midrun_rst_valid", {15'd0, bus.pc_valid}, 16'h0001);
    res = 1'b0;
    rdy = 1'b1;
    cyc();
    check("post_rst_inc", bus.pc, 16'h8001);
    drive(1'b0, 1'b0, 1'b1, 8'h44);
    cyc();
    check("rst_clears_pcl", bus.pc, 16'h4400);
`endif

    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
